// File: rtl/ped_req_pkg.sv
// rtl/ped_req_pkg.sv - shared state enum and default parameters for the pedestrian request conditioner.
package ped_req_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LOCKOUT_CYCLES  = 16;
  localparam logic [7:0] PRESS_COUNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_LOCKOUT
  } ped_req_state_t;

endpackage

// File: rtl/ped_sync.sv
// rtl/ped_sync.sv - multi-flop synchronizer for the asynchronous button input, cleared to 0 on reset.
module ped_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/ped_request_conditioner.sv
// rtl/ped_request_conditioner.sv - debounces the pedestrian button into a held request plus press strobe.
// Optional accepted-press counter enabled by defining PED_REQ_COUNT_EN.
module ped_request_conditioner
  import ped_req_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       req_ack,
  output logic       req,
  output logic       press_pulse,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCKOUT_CYCLES);

  ped_req_state_t  r_state;
  logic [DB_W-1:0] r_db_cnt;
  logic [LK_W-1:0] r_lk_cnt;
  logic            r_press_pulse;
  logic            r_req;
  logic            w_btn_s;
  logic            w_accept;

  ped_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (button_raw),
    .o_sync  (w_btn_s)
  );

  assign w_accept = (r_state == ST_DEBOUNCE) && w_btn_s && (r_db_cnt == DB_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_db_cnt      <= '0;
      r_lk_cnt      <= '0;
      r_press_pulse <= 1'b0;
      r_req         <= 1'b0;
    end else begin
      r_press_pulse <= w_accept;
      // A new press always wins over an acknowledge in the same cycle.
      r_req         <= w_accept | (r_req & ~req_ack);
      case (r_state)
        ST_IDLE: begin
          if (w_btn_s) begin
            r_state  <= ST_DEBOUNCE;
            r_db_cnt <= DB_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!w_btn_s) begin
            r_state  <= ST_IDLE;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_MAX) begin
            r_state  <= ST_HELD;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
        ST_HELD: begin
          if (!w_btn_s) begin
            r_state  <= ST_LOCKOUT;
            r_lk_cnt <= LK_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (r_lk_cnt == LK_MAX) begin
            r_state  <= ST_IDLE;
            r_lk_cnt <= '0;
          end else begin
            r_lk_cnt <= r_lk_cnt + LK_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req         = r_req;
  assign press_pulse = r_press_pulse;
  assign busy        = (r_state != ST_IDLE);

`ifdef PED_REQ_COUNT_EN
  logic [7:0] r_press_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_count <= 8'd0;
    end else if (w_accept && (r_press_count != PRESS_COUNT_MAX)) begin
      r_press_count <= r_press_count + 8'd1;
    end
  end

  assign press_count = r_press_count;
`else
  assign press_count = 8'd0;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
// tb/tb_ped_request_conditioner.sv - directed and random checks of the request conditioner against a history-based model.
module tb_ped_request_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int L = 16;
  localparam int HIST = 16384;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button_raw = 1'b0;
  logic       req_ack = 1'b0;
  logic       req;
  logic       press_pulse;
  logic       busy;
  logic [7:0] press_count;

  ped_request_conditioner #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .LOCKOUT_CYCLES  (L)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_raw  (button_raw),
    .req_ack     (req_ack),
    .req         (req),
    .press_pulse (press_pulse),
    .busy        (busy),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: raw input history, reset edge, and the first edge at which the button is looked at again.
  bit   raw_hist [HIST];
  int   t = 0;
  int   rst_edge = 0;
  int   ready_t = 1;
  bit   m_held = 0;
  bit   m_req = 0;
  bit   m_pulse = 0;
  bit   m_busy = 0;
  int   m_cnt = 0;
  int   pulses = 0;
  int   pulse_t = -1;

  function automatic bit samp(int tt);
    if (tt - S <= rst_edge) return 1'b0;
    return raw_hist[tt - S];
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit a, input bit rs);
    int ones;
    button_raw = r;
    req_ack    = a;
    reset      = rs;
    @(posedge clk);
    t++;
    raw_hist[t] = r;
    m_pulse = 1'b0;
    ones = 0;
    if (rs) begin
      rst_edge = t;
      ready_t  = t + 1;
      m_held   = 1'b0;
      m_req    = 1'b0;
      m_cnt    = 0;
    end else begin
      if (m_held) begin
        if (!samp(t)) begin
          m_held  = 1'b0;
          ready_t = t + L + 1;
        end
      end else if (t >= ready_t) begin
        for (int k = t; k >= ready_t && ones <= D; k--) begin
          if (samp(k)) ones++;
          else break;
        end
        if (ones == D + 1) begin
          m_pulse = 1'b1;
          m_held  = 1'b1;
        end
      end
      if (m_pulse) m_req = 1'b1;
      else if (a) m_req = 1'b0;
`ifdef PED_REQ_COUNT_EN
      if (m_pulse && m_cnt < 255) m_cnt++;
`endif
    end
    m_busy = m_held || (t + 1 < ready_t) || (!m_held && t >= ready_t && ones > 0);
    #1;
    if (press_pulse === 1'b1) begin
      pulses++;
      if (pulse_t < 0) pulse_t = t;
    end
    check("req", {7'd0, req}, {7'd0, m_req});
    check("press_pulse", {7'd0, press_pulse}, {7'd0, m_pulse});
    check("busy", {7'd0, busy}, {7'd0, m_busy});
    check("press_count", press_count, 8'(m_cnt));
  endtask

  task automatic run(input bit r, input int n);
    for (int i = 0; i < n; i++) tick(r, 1'b0, 1'b0);
  endtask

  initial begin
    int rise_t;
    int len;
    bit lvl;

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    run(1'b0, 4);

    // Clean press: one pulse at a latency of 7, busy until lockout expires.
    pulses  = 0;
    pulse_t = -1;
    rise_t  = t + 1;
    run(1'b1, 30);
    check("clean_pulses", 8'(pulses), 8'd1);
    check("clean_latency", 8'(pulse_t - rise_t + 1), 8'd7);
    run(1'b0, 24);
    check("clean_idle", {7'd0, busy}, 8'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("ack_clears", {7'd0, req}, 8'd0);

    // Bounce: short highs never accepted.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 3);
      run(1'b0, 3);
    end
    run(1'b0, 4);
    check("bounce_pulses", 8'(pulses), 8'd0);
    check("bounce_req", {7'd0, req}, 8'd0);

    // Lockout: re-press inside lockout ignored, later re-press accepted and merged into req.
    run(1'b1, 20);
    pulses = 0;
    run(1'b0, 5);
    run(1'b1, 10);
    run(1'b0, 5);
    check("lockout_ignored", 8'(pulses), 8'd0);
    run(1'b1, 10);
    check("lockout_second", 8'(pulses), 8'd1);
    check("merge_req", {7'd0, req}, 8'd1);
    run(1'b0, 24);

    // Handshake: ack coinciding with the pulse loses; ack alone clears.
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("set_wins_pulse", {7'd0, press_pulse}, 8'd1);
    check("set_wins_req", {7'd0, req}, 8'd1);
    tick(1'b1, 1'b1, 1'b0);
    check("ack_after", {7'd0, req}, 8'd0);
    run(1'b1, 5);
    run(1'b0, 24);

    // Reset while debouncing at count 3 abandons the press.
    pulses = 0;
    run(1'b1, 5);
    tick(1'b0, 1'b0, 1'b1);
    run(1'b0, 10);
    check("rst_mid_pulses", 8'(pulses), 8'd0);

    // Random bursts with sporadic acks and resets.
    for (int seg = 0; seg < 200; seg++) begin
      len = $urandom_range(1, 12);
      lvl = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++)
        tick(lvl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
    end

`ifdef PED_REQ_COUNT_EN
    tick(1'b0, 1'b0, 1'b1);
    run(1'b0, 3);
    for (int p = 0; p < 300; p++) begin
      run(1'b1, 8);
      run(1'b0, 22);
    end
    check("count_saturated", press_count, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
